// File: rtl/robo_pkg.sv
// Shared definitions for the robot environment model: headings, drive commands
// and the per-heading unit step on the grid.
package robo_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  // Encoded as {avancar, girar}
  typedef enum logic [1:0] {
    CMD_HOLD    = 2'b00,
    CMD_GIRAR   = 2'b01,
    CMD_AVANCAR = 2'b10,
    CMD_ILEGAL  = 2'b11
  } cmd_t;

  typedef struct packed {
    logic signed [1:0] dx;
    logic signed [1:0] dy;
  } delta_t;

  // 8x8 grid, outer ring walled, interior free (byte y holds row y)
  localparam logic [63:0] MAPA_BORDA_8X8 = 64'hFF81_8181_8181_81FF;

  function automatic delta_t delta(input dir_t d);
    delta_t r;
    r.dx = '0;
    r.dy = '0;
    case (d)
      DIR_N: r.dy = -2'sd1;
      DIR_E: r.dx = 2'sd1;
      DIR_S: r.dy = 2'sd1;
      DIR_W: r.dx = -2'sd1;
      default: ;
    endcase
    return r;
  endfunction

  function automatic dir_t gira(input dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t esquerda(input dir_t d);
    return dir_t'(d - 2'd1);
  endfunction

endpackage

// File: rtl/robo_vizinho.sv
// Wall lookup for the neighbour of (x,y) in direction d; anything off-grid is a wall.
module robo_vizinho
  import robo_pkg::*;
#(
  parameter int LARGURA = 8,
  parameter int ALTURA  = 8,
  parameter logic [LARGURA*ALTURA-1:0] MAPA = '0
) (
  input  logic [$clog2(LARGURA)-1:0] x,
  input  logic [$clog2(ALTURA)-1:0]  y,
  input  dir_t                       d,
  output logic                       parede
);

  localparam int IW = $clog2(LARGURA*ALTURA);

  delta_t        dl;
  int            nx;
  int            ny;
  logic [IW-1:0] idx;

  always_comb begin
    dl     = delta(d);
    nx     = int'(x) + int'(dl.dx);
    ny     = int'(y) + int'(dl.dy);
    idx    = '0;
    parede = 1'b1;
    if (nx >= 0 && nx < LARGURA && ny >= 0 && ny < ALTURA) begin
      idx    = IW'(ny * LARGURA + nx);
      parede = MAPA[idx];
    end
  end

endmodule

// File: rtl/robo_ambiente.sv
// World model for the robot: tracks cell/heading on a walled grid and produces
// the head/left wall sensors plus collision, command-error, lap and step status.
module robo_ambiente
  import robo_pkg::*;
#(
  parameter int LARGURA   = 8,
  parameter int ALTURA    = 8,
  parameter logic [LARGURA*ALTURA-1:0] MAPA = MAPA_BORDA_8X8,
  parameter int START_X   = 1,
  parameter int START_Y   = 1,
  parameter int START_DIR = 0,
  parameter int PASSOS_W  = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       avancar,
  input  logic                       girar,
  output logic                       head,
  output logic                       left,
  output logic [$clog2(LARGURA)-1:0] pos_x,
  output logic [$clog2(ALTURA)-1:0]  pos_y,
  output logic [1:0]                 dir,
  output logic                       colisao,
  output logic                       cmd_erro,
  output logic                       volta,
  output logic [PASSOS_W-1:0]        passos
);

  localparam int XW = $clog2(LARGURA);
  localparam int YW = $clog2(ALTURA);

  if (MAPA[START_Y*LARGURA + START_X]) begin : g_start_walled
    $error("robo_ambiente: start cell (%0d,%0d) is a wall in MAPA", START_X, START_Y);
  end

  dir_t                dir_q, dir_n, dir_esq;
  logic [XW-1:0]       x_n;
  logic [YW-1:0]       y_n;
  logic                col_n, err_n, volta_n;
  logic [PASSOS_W-1:0] passos_n;
  cmd_t                cmd;
  delta_t              dl;

  assign dir     = dir_q;
  assign dir_esq = esquerda(dir_q);

  robo_vizinho #(.LARGURA(LARGURA), .ALTURA(ALTURA), .MAPA(MAPA)) u_frente (
    .x(pos_x), .y(pos_y), .d(dir_q), .parede(head)
  );

  robo_vizinho #(.LARGURA(LARGURA), .ALTURA(ALTURA), .MAPA(MAPA)) u_esquerda (
    .x(pos_x), .y(pos_y), .d(dir_esq), .parede(left)
  );

  always_comb begin
    cmd      = cmd_t'({avancar, girar});
    dl       = delta(dir_q);
    x_n      = pos_x;
    y_n      = pos_y;
    dir_n    = dir_q;
    col_n    = colisao;
    err_n    = cmd_erro;
    volta_n  = 1'b0;
    passos_n = passos;
    case (cmd)
      CMD_AVANCAR: begin
        if (head) begin
          col_n = 1'b1;
        end else begin
          // head=0 guarantees the ahead cell is on-grid, so no wrap can occur
          x_n     = XW'(int'(pos_x) + int'(dl.dx));
          y_n     = YW'(int'(pos_y) + int'(dl.dy));
          volta_n = (x_n == XW'(START_X)) && (y_n == YW'(START_Y));
          if (passos != '1) passos_n = passos + PASSOS_W'(1);
        end
      end
      CMD_GIRAR:  dir_n = gira(dir_q);
      CMD_ILEGAL: err_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pos_x    <= XW'(START_X);
      pos_y    <= YW'(START_Y);
      dir_q    <= dir_t'(START_DIR);
      colisao  <= 1'b0;
      cmd_erro <= 1'b0;
      volta    <= 1'b0;
      passos   <= '0;
    end else begin
      pos_x    <= x_n;
      pos_y    <= y_n;
      dir_q    <= dir_n;
      colisao  <= col_n;
      cmd_erro <= err_n;
      volta    <= volta_n;
      passos   <= passos_n;
    end
  end

endmodule

// File: tb/tb_robo_ambiente.sv
// Bench for robo_ambiente on the default 8x8 border maze: directed scenarios with
// literal expectations, a closed-loop controller, and random commands vs a grid model.
module tb_robo_ambiente;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        avancar = 1'b0;
  logic        girar = 1'b0;
  logic        head, left, colisao, cmd_erro, volta;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  dir;
  logic [15:0] passos;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  localparam int DX[4] = '{0, 1, 0, -1};
  localparam int DY[4] = '{-1, 0, 1, 0};

  robo_ambiente #(
    .LARGURA(8), .ALTURA(8), .START_X(1), .START_Y(1), .START_DIR(0), .PASSOS_W(16)
  ) dut (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
    .head(head), .left(left), .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .colisao(colisao), .cmd_erro(cmd_erro), .volta(volta), .passos(passos)
  );

  always #5 clock = ~clock;

  // Reference world: coordinates as plain integers, walls from the maze description
  int mx = 1, my = 1, md = 0, mp = 0;
  bit mcol = 0, merr = 0, mvolta = 0;

  function automatic bit wall(input int x, input int y);
    if (x < 0 || x >= 8 || y < 0 || y >= 8) return 1'b1;
    return (x == 0 || x == 7 || y == 0 || y == 7);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mx <= 1; my <= 1; md <= 0; mp <= 0;
      mcol <= 0; merr <= 0; mvolta <= 0;
    end else begin
      mvolta <= 0;
      if (avancar && girar) begin
        merr <= 1;
      end else if (avancar) begin
        if (wall(mx + DX[md], my + DY[md])) begin
          mcol <= 1;
        end else begin
          mx <= mx + DX[md];
          my <= my + DY[md];
          if (mp < 65535) mp <= mp + 1;
          if (mx + DX[md] == 1 && my + DY[md] == 1) mvolta <= 1;
        end
      end else if (girar) begin
        md <= (md + 1) % 4;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("m.pos_x", int'(pos_x), mx);
      chk("m.pos_y", int'(pos_y), my);
      chk("m.dir", int'(dir), md);
      chk("m.head", int'(head), int'(wall(mx + DX[md], my + DY[md])));
      chk("m.left", int'(left), int'(wall(mx + DX[(md + 3) % 4], my + DY[(md + 3) % 4])));
      chk("m.colisao", int'(colisao), int'(mcol));
      chk("m.cmd_erro", int'(cmd_erro), int'(merr));
      chk("m.volta", int'(volta), int'(mvolta));
      chk("m.passos", int'(passos), mp);
    end
  end

  // Apply a command at a falling edge; returns at the next falling edge
  task automatic drive(input bit av, input bit gi);
    avancar = av;
    girar   = gi;
    @(negedge clock);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pos_x"}, int'(pos_x), 1);
    chk({tag, ".pos_y"}, int'(pos_y), 1);
    chk({tag, ".dir"}, int'(dir), 0);
    chk({tag, ".head"}, int'(head), 1);
    chk({tag, ".left"}, int'(left), 1);
    chk({tag, ".passos"}, int'(passos), 0);
    chk({tag, ".colisao"}, int'(colisao), 0);
    chk({tag, ".cmd_erro"}, int'(cmd_erro), 0);
    chk({tag, ".volta"}, int'(volta), 0);
  endtask

  task automatic do_reset();
    avancar = 0;
    girar   = 0;
    reset   = 1;
    @(negedge clock);
    reset   = 0;
  endtask

  int nvolta;
  int first_passos;
  int r;

  initial begin
    #1 reset = 1;
    @(negedge clock);
    chk_reset_state("reset");
    reset  = 0;
    chk_en = 1;

    // Rotation
    drive(0, 1);
    chk("rot.dir", int'(dir), 1);
    chk("rot.head", int'(head), 0);
    chk("rot.left", int'(left), 1);
    drive(0, 1); drive(0, 1); drive(0, 1);
    chk("rot4.dir", int'(dir), 0);
    chk("rot4.head", int'(head), 1);
    drive(0, 1);

    // Run east into the wall
    for (int k = 1; k <= 5; k++) begin
      drive(1, 0);
      chk("run.pos_x", int'(pos_x), 1 + k);
    end
    chk("run.passos", int'(passos), 5);
    chk("run.colisao", int'(colisao), 0);
    chk("run.head", int'(head), 1);
    drive(1, 0);
    chk("bump.pos_x", int'(pos_x), 6);
    chk("bump.colisao", int'(colisao), 1);
    chk("bump.passos", int'(passos), 5);

    // Illegal command
    drive(1, 1);
    chk("ileg.cmd_erro", int'(cmd_erro), 1);
    chk("ileg.pos_x", int'(pos_x), 6);
    chk("ileg.dir", int'(dir), 1);
    chk("ileg.passos", int'(passos), 5);
    drive(0, 0);
    chk("hold.cmd_erro", int'(cmd_erro), 1);
    chk("hold.colisao", int'(colisao), 1);

    // Asynchronous reset between edges
    drive(0, 1);
    drive(1, 0);
    chk("pre.pos_y", int'(pos_y), 2);
    avancar = 0;
    girar   = 0;
    @(posedge clock);
    #2 reset = 1;
    #1 chk_reset_state("async");
    @(negedge clock);
    reset = 0;

    // Closed loop with a turn-when-blocked controller
    do_reset();
    nvolta = 0;
    first_passos = -1;
    for (int c = 0; c < 200; c++) begin
      drive(!head, head);
      if (volta) begin
        nvolta++;
        if (first_passos < 0) first_passos = int'(passos);
      end
    end
    chk("loop.voltas", nvolta, 8);
    chk("loop.first_passos", first_passos, 20);
    chk("loop.colisao", int'(colisao), 0);
    chk("loop.cmd_erro", int'(cmd_erro), 0);

    // Random commands against the model
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 199));
      if (r < 2) begin
        do_reset();
      end else if (r < 95) begin
        drive(1, 0);
      end else if (r < 170) begin
        drive(0, 1);
      end else if (r < 173) begin
        drive(1, 1);
      end else begin
        drive(0, 0);
      end
    end

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
